sync_conditioner: RTL and testbench
===================================

SYNC_CONDITIONER -- requirements
Module: sync_conditioner

Interface
REQ-001 SHALL have parameter CHANNELS, default 3, meaning number of independent video channels.
REQ-002 SHALL have parameter RESOLUTION, default 6, meaning sample width per channel.
REQ-003 SHALL have parameter DAC_RESOLUTION, default 6 (<= RESOLUTION), meaning sigma-delta DAC input width, taken from the sample MSBs.
REQ-004 SHALL have parameter HEADROOM, default 24, meaning limiter span above black level.
REQ-005 SHALL have parameter AVG_LOG2, default 3, meaning log2 of the number of porch samples averaged per black-level update.
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port ce  input  1  sample enable.
REQ-009 SHALL have port hsync_n  input  1  horizontal sync, active-low.
REQ-010 SHALL have port vsync_n  input  1  vertical sync, active-low.
REQ-011 SHALL have port porch  input  1  back-porch window, active-high.
REQ-012 SHALL have port mode  input  2  0 bypass, 1 sync cut, 2 sync cut + clamp/limit, 3 test ramp.
REQ-013 SHALL have port samples_i  input  CHANNELS*RESOLUTION  packed samples, channel 0 in the LSBs.
REQ-014 SHALL have port cond_o  output  CHANNELS*RESOLUTION  conditioned samples, same packing.
REQ-015 SHALL have port blacklevel_o  output  CHANNELS*RESOLUTION  current per-channel black level.
REQ-016 SHALL have port valid_o  output  1  one-cycle pulse when cond_o updates.
REQ-017 SHALL have port dac_o  output  CHANNELS  per-channel 1-bit sigma-delta DAC stream.

Function
REQ-018 SHALL derive composite sync xsync = NOT(hsync_n XOR vsync_n); sync is active when xsync = 0.
REQ-019 SHALL register cond_o on a clk edge where ce = 1; latency 1 clk; valid_o = 1 on the cycle after ce = 1, else 0.
REQ-020 SHALL hold cond_o when ce = 0.
REQ-021 Mode 0 SHALL set cond = sample.
REQ-022 Mode 1 SHALL set cond = 0 if sync is active, else sample.
REQ-023 Mode 2 SHALL apply this priority: sync -> 0; porch -> black; sample < black -> black; sample > black+HEADROOM -> black+HEADROOM; else sample.
REQ-024 SHALL compute black+HEADROOM in RESOLUTION+1 bits and saturate it to 2^RESOLUTION-1.
REQ-025 Mode 3 SHALL output a shared RESOLUTION-bit ramp on all channels: +1 per ce, wrapping at 2^RESOLUTION-1 -> 0; cleared to 0 on a ce when sync is active.
REQ-026 SHALL run the per-channel black-level FSM IDLE/ACCUM/HOLD as follows:
- IDLE: on ce with porch = 1, load acc = sample, cnt = 1, go to ACCUM.
- ACCUM: on ce with porch = 1, acc += sample, cnt += 1.
- ACCUM: when cnt reaches 2^AVG_LOG2, black <= acc >> AVG_LOG2 on the same cycle, go to HOLD.
- ACCUM: if porch = 0 before cnt is full, discard the partial sum, leave black unchanged, go to IDLE.
- HOLD: go to IDLE when porch = 0.
REQ-027 SHALL size acc at RESOLUTION+AVG_LOG2 bits so that it never overflows.
REQ-028 SHALL have all channels share the FSM timing (one state/cnt) while keeping acc and black per channel.
REQ-029 SHALL update the FSM in all modes; mode 2 SHALL use the black value registered before the current sample.
REQ-030 SHALL have each channel's DAC run every clk, independent of ce: acc_d (DAC_RESOLUTION+1 bits) <= acc_d[DAC_RESOLUTION-1:0] + cond[RESOLUTION-1 -: DAC_RESOLUTION].
REQ-031 SHALL drive dac_o = acc_d[DAC_RESOLUTION] (carry).
REQ-032 SHALL make a mode change take effect on the next ce sample, with no FSM reset.

Reset
REQ-033 On rst SHALL asynchronously clear cond_o, blacklevel_o, valid_o, dac_o, the ramp, acc, cnt and acc_d to 0, and set the FSM to IDLE.
REQ-034 SHALL resume operation on the first clk edge after rst deasserts; a porch window already in progress at release SHALL be entered from IDLE.

Verification
REQ-035 Bench SHALL cover: R=6, AVG_LOG2=3, ce=1, porch high 8 cycles, samples 10,10,10,10,12,12,12,12 -> blacklevel_o = 11 after the 8th sample; porch held 20 more cycles -> no further change.
REQ-036 Bench SHALL cover: porch high for only 5 samples of 30 -> blacklevel_o keeps its previous value.
REQ-037 Bench SHALL cover: mode 2, black = 11, HEADROOM = 24, samples 5/20/40, sync inactive, porch = 0 -> cond 11/20/35; then hsync_n = 0, vsync_n = 1 -> cond 0.
REQ-038 Bench SHALL cover: black = 50, HEADROOM = 24, sample 63 -> cond 63 (saturation, no wrap).
REQ-039 Bench SHALL cover: constant cond = 32, DAC_RESOLUTION = 6 -> dac_o duty exactly 1/2 over 64 clk; cond = 0 -> dac_o constantly 0.
REQ-040 Bench SHALL cover: rst asserted mid-ACCUM -> all outputs 0 immediately, without waiting for a clk edge; after release the next full porch produces a correct average.

Source files
------------

// File: rtl/sync_conditioner.sv
// Video sync conditioner: per-channel sync cut, black-level clamp/limit, test ramp,
// porch-averaged black level estimation and first-order sigma-delta DAC outputs.
module sync_conditioner #(
   parameter int CHANNELS       = 3,
   parameter int RESOLUTION     = 6,
   parameter int DAC_RESOLUTION = 6,
   parameter int HEADROOM       = 24,
   parameter int AVG_LOG2       = 3
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           ce,
   input  logic                           hsync_n,
   input  logic                           vsync_n,
   input  logic                           porch,
   input  logic [1:0]                     mode,
   input  logic [CHANNELS*RESOLUTION-1:0] samples_i,
   output logic [CHANNELS*RESOLUTION-1:0] cond_o,
   output logic [CHANNELS*RESOLUTION-1:0] blacklevel_o,
   output logic                           valid_o,
   output logic [CHANNELS-1:0]            dac_o
);
   // state | meaning
   // IDLE  | waiting for the first porch sample of a line
   // ACCUM | summing porch samples until 2^AVG_LOG2 have been taken
   // HOLD  | black level updated, waiting for the porch window to close

   localparam int R  = RESOLUTION;
   localparam int D  = DAC_RESOLUTION;
   localparam int AW = RESOLUTION + AVG_LOG2;
   localparam int CW = AVG_LOG2 + 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(1 << AVG_LOG2);
   localparam logic [R:0]    HEAD     = (R+1)'(HEADROOM);
   localparam logic [R:0]    SAT      = {1'b0, {R{1'b1}}};

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   state_t                         state, state_nx;
   logic [CW-1:0]                  cnt, cnt_nx;
   logic [R-1:0]                   ramp, ramp_nx;
   logic [CHANNELS-1:0][R-1:0]     smp;
   logic [CHANNELS-1:0][R-1:0]     cond, cond_nx;
   logic [CHANNELS-1:0][R-1:0]     black, black_nx;
   logic [CHANNELS-1:0][AW-1:0]    acc, acc_nx;
   logic [CHANNELS-1:0][R:0]       lim;
   logic [CHANNELS-1:0][D:0]       acc_d;
   logic                           sync_act;
   logic                           load, add, done;

   assign smp          = samples_i;
   assign cond_o       = cond;
   assign blacklevel_o = black;
   // Composite sync is active when exactly one of the two syncs is asserted.
   assign sync_act     = hsync_n ^ vsync_n;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      load     = 1'b0;
      add      = 1'b0;
      done     = 1'b0;
      unique case (state)
         IDLE: begin
            if (ce && porch) begin
               state_nx = ACCUM;
               cnt_nx   = CW'(1);
               load     = 1'b1;
            end
         end
         ACCUM: begin
            if (!porch) begin
               state_nx = IDLE;
            end else if (ce) begin
               cnt_nx = cnt + 1'b1;
               add    = 1'b1;
            end
         end
         HOLD: begin
            if (!porch) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      if ((load || add) && cnt_nx == CNT_FULL) begin
         done     = 1'b1;
         state_nx = HOLD;
      end
   end

   always_comb begin
      acc_nx   = acc;
      black_nx = black;
      for (int ch = 0; ch < CHANNELS; ch++) begin
         if (load) acc_nx[ch] = AW'(smp[ch]);
         if (add)  acc_nx[ch] = acc[ch] + AW'(smp[ch]);
         if (done) black_nx[ch] = R'(acc_nx[ch] >> AVG_LOG2);
      end
   end

   always_comb begin
      ramp_nx = sync_act ? '0 : ramp + 1'b1;
      cond_nx = cond;
      lim     = '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
         lim[ch] = {1'b0, black[ch]} + HEAD;
         if (lim[ch] > SAT) lim[ch] = SAT;
         unique case (mode)
            2'd0: cond_nx[ch] = smp[ch];
            2'd1: cond_nx[ch] = sync_act ? '0 : smp[ch];
            2'd2: begin
               if (sync_act)                      cond_nx[ch] = '0;
               else if (porch)                    cond_nx[ch] = black[ch];
               else if (smp[ch] < black[ch])      cond_nx[ch] = black[ch];
               else if ({1'b0, smp[ch]} > lim[ch]) cond_nx[ch] = lim[ch][R-1:0];
               else                               cond_nx[ch] = smp[ch];
            end
            default: cond_nx[ch] = ramp_nx;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         acc     <= '0;
         black   <= '0;
         cond    <= '0;
         ramp    <= '0;
         valid_o <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         acc     <= acc_nx;
         black   <= black_nx;
         valid_o <= ce;
         if (ce) begin
            cond <= cond_nx;
            ramp <= ramp_nx;
         end
      end
   end

   // DAC runs every clock from the registered conditioned sample MSBs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_d <= '0;
      end else begin
         for (int ch = 0; ch < CHANNELS; ch++)
            acc_d[ch] <= {1'b0, acc_d[ch][D-1:0]} + {1'b0, cond[ch][R-1 -: D]};
      end
   end

   always_comb begin
      dac_o = '0;
      for (int ch = 0; ch < CHANNELS; ch++) dac_o[ch] = acc_d[ch][D];
   end

endmodule

// File: tb/tb_sync_conditioner.sv
// Scoreboard bench for sync_conditioner: reference model pushes expected samples,
// a monitor pops them whenever valid_o is seen.
module tb_sync_conditioner;
   localparam int C = 3;
   localparam int R = 6;
   localparam int H = 24;
   localparam int N = 8;
   localparam int MAXV = 63;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           ce = 1'b0;
   logic           hsync_n = 1'b1;
   logic           vsync_n = 1'b1;
   logic           porch = 1'b0;
   logic [1:0]     mode = 2'd0;
   logic [C*R-1:0] samples_i = '0;
   logic [C*R-1:0] cond_o;
   logic [C*R-1:0] blacklevel_o;
   logic           valid_o;
   logic [C-1:0]   dac_o;

   int checks = 0;
   int errors = 0;

   sync_conditioner #(
      .CHANNELS(C), .RESOLUTION(R), .DAC_RESOLUTION(6), .HEADROOM(H), .AVG_LOG2(3)
   ) dut (
      .clk(clk), .rst(rst), .ce(ce), .hsync_n(hsync_n), .vsync_n(vsync_n),
      .porch(porch), .mode(mode), .samples_i(samples_i), .cond_o(cond_o),
      .blacklevel_o(blacklevel_o), .valid_o(valid_o), .dac_o(dac_o)
   );

   always #5 clk = ~clk;

   // reference model state
   logic [C*R-1:0] exp_q[$];
   int             m_black[C];
   int             m_sum[C];
   int             m_n;
   bit             m_done;
   int             m_ramp;
   logic [C*R-1:0] m_black_pk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int clampv(input int s, input int b, input int p, input bit sy,
                                 input int m, input int rmp);
      int top;
      top = (b + H > MAXV) ? MAXV : b + H;
      case (m)
         0: return s;
         1: return sy ? 0 : s;
         2: begin
            if (sy) return 0;
            if (p != 0) return b;
            if (s < b) return b;
            if (s > top) return top;
            return s;
         end
         default: return rmp;
      endcase
   endfunction

   initial begin
      m_n = 0; m_done = 0; m_ramp = 0;
      foreach (m_black[i]) begin m_black[i] = 0; m_sum[i] = 0; end
      m_black_pk = '0;
      forever begin
         @(posedge clk);
         if (rst) begin
            m_n = 0; m_done = 0; m_ramp = 0;
            foreach (m_black[i]) begin m_black[i] = 0; m_sum[i] = 0; end
            m_black_pk = '0;
            exp_q.delete();
         end else begin
            bit sy;
            logic [C*R-1:0] e;
            sy = (hsync_n != vsync_n);
            if (ce) begin
               m_ramp = sy ? 0 : (m_ramp + 1) % (MAXV + 1);
               for (int ch = 0; ch < C; ch++)
                  e[ch*R +: R] = R'(clampv(int'(samples_i[ch*R +: R]), m_black[ch],
                                           int'(porch), sy, int'(mode), m_ramp));
               exp_q.push_back(e);
            end
            if (!porch) begin
               m_n = 0; m_done = 0;
               foreach (m_sum[i]) m_sum[i] = 0;
            end else if (ce && !m_done) begin
               for (int ch = 0; ch < C; ch++) m_sum[ch] += int'(samples_i[ch*R +: R]);
               m_n++;
               if (m_n == N) begin
                  for (int ch = 0; ch < C; ch++) m_black[ch] = m_sum[ch] / N;
                  m_done = 1;
               end
            end
            for (int ch = 0; ch < C; ch++) m_black_pk[ch*R +: R] = R'(m_black[ch]);
         end
      end
   end

   // monitor
   initial begin
      logic [C*R-1:0] last_exp;
      logic [C*R-1:0] e;
      last_exp = '0;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            last_exp = '0;
         end else if (valid_o) begin
            if (exp_q.size() == 0) begin
               check("valid_without_sample", 64'(valid_o), 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("cond", 64'(cond_o), 64'(e));
               last_exp = e;
            end
         end else begin
            if (exp_q.size() != 0) begin
               check("valid_missing", 64'(valid_o), 64'd1);
               exp_q.delete();
            end
            check("cond_hold", 64'(cond_o), 64'(last_exp));
         end
         if (!rst) check("blacklevel", 64'(blacklevel_o), 64'(m_black_pk));
      end
   end

   function automatic logic [C*R-1:0] pk(input int a, input int b, input int c);
      logic [C*R-1:0] v;
      v = {R'(c), R'(b), R'(a)};
      return v;
   endfunction

   task automatic step(input logic c, input logic p, input logic hs, input logic vs,
                       input logic [1:0] m, input logic [C*R-1:0] s);
      ce = c; porch = p; hsync_n = hs; vsync_n = vs; mode = m; samples_i = s;
      @(posedge clk);
      #2;
   endtask

   initial begin
      int ones[C];
      int prun;
      logic p;
      logic [1:0] m;

      #23;
      check("reset_cond", 64'(cond_o), 64'd0);
      check("reset_black", 64'(blacklevel_o), 64'd0);
      check("reset_valid", 64'(valid_o), 64'd0);
      check("reset_dac", 64'(dac_o), 64'd0);
      rst = 1'b0;

      // porch average 10x4, 12x4 -> 11
      for (int i = 0; i < 8; i++)
         step(1, 1, 1, 1, 0, pk(i < 4 ? 10 : 12, 20 + i, 40));
      check("black_after_8", 64'(blacklevel_o[R-1:0]), 64'd11);
      for (int i = 0; i < 20; i++)
         step(1, 1, 1, 1, 0, pk($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63)));
      check("black_hold_porch", 64'(blacklevel_o[R-1:0]), 64'd11);
      step(1, 0, 1, 1, 0, pk(1, 2, 3));

      // short porch: 5 of 30 samples
      for (int i = 0; i < 30; i++)
         step(1, i < 5, 1, 1, 0, pk($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63)));
      check("black_short_porch", 64'(blacklevel_o[R-1:0]), 64'd11);

      // clamp / limit
      step(1, 0, 1, 1, 2, pk(5, 5, 5));
      check("clamp_low", 64'(cond_o[R-1:0]), 64'd11);
      step(1, 0, 1, 1, 2, pk(20, 20, 20));
      check("pass_mid", 64'(cond_o[R-1:0]), 64'd20);
      step(1, 0, 1, 1, 2, pk(40, 40, 40));
      check("limit_high", 64'(cond_o[R-1:0]), 64'd35);
      step(1, 0, 0, 1, 2, pk(40, 40, 40));
      check("sync_cut", 64'(cond_o[R-1:0]), 64'd0);

      // saturation of black+HEADROOM
      for (int i = 0; i < 8; i++) step(1, 1, 1, 1, 0, pk(50, 50, 50));
      step(1, 0, 1, 1, 0, pk(0, 0, 0));
      check("black_50", 64'(blacklevel_o[R-1:0]), 64'd50);
      step(1, 0, 1, 1, 2, pk(63, 63, 63));
      check("saturate", 64'(cond_o[R-1:0]), 64'd63);

      // ramp and sync cut
      for (int i = 0; i < 80; i++)
         step($urandom_range(0, 3) != 0, 0, $urandom_range(0, 9) != 0, 1, 3, pk(0, 0, 0));
      for (int i = 0; i < 30; i++)
         step(1, 0, $urandom_range(0, 1), $urandom_range(0, 1), 1,
              pk($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63)));

      // randomized mix
      prun = 0; p = 0; m = 0;
      for (int i = 0; i < 600; i++) begin
         if (prun == 0) begin p = ~p; prun = $urandom_range(1, 14); end
         prun--;
         if ($urandom_range(0, 39) == 0) m = 2'($urandom_range(0, 3));
         step($urandom_range(0, 3) != 0, p, $urandom_range(0, 7) != 0,
              $urandom_range(0, 15) != 0, m,
              pk($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63)));
      end

      // DAC duty: cond 32 -> half, cond 0 -> never
      step(1, 0, 1, 1, 0, pk(32, 32, 32));
      step(0, 0, 1, 1, 0, pk(0, 0, 0));
      step(0, 0, 1, 1, 0, pk(0, 0, 0));
      foreach (ones[i]) ones[i] = 0;
      for (int i = 0; i < 64; i++) begin
         for (int ch = 0; ch < C; ch++) ones[ch] += int'(dac_o[ch]);
         step(0, 0, 1, 1, 0, pk(0, 0, 0));
      end
      for (int ch = 0; ch < C; ch++) check("dac_duty_32", 64'(ones[ch]), 64'd32);
      step(1, 0, 1, 1, 0, pk(0, 0, 0));
      step(0, 0, 1, 1, 0, pk(0, 0, 0));
      step(0, 0, 1, 1, 0, pk(0, 0, 0));
      foreach (ones[i]) ones[i] = 0;
      for (int i = 0; i < 64; i++) begin
         for (int ch = 0; ch < C; ch++) ones[ch] += int'(dac_o[ch]);
         step(0, 0, 1, 1, 0, pk(0, 0, 0));
      end
      for (int ch = 0; ch < C; ch++) check("dac_zero", 64'(ones[ch]), 64'd0);

      // reset in the middle of an accumulation
      for (int i = 0; i < 8; i++) step(1, 1, 1, 1, 0, pk(44, 44, 44));
      step(1, 0, 1, 1, 0, pk(60, 60, 60));
      for (int i = 0; i < 4; i++) step(1, 1, 1, 1, 0, pk(20, 20, 20));
      rst = 1'b1;
      #1;
      check("async_rst_cond", 64'(cond_o), 64'd0);
      check("async_rst_black", 64'(blacklevel_o), 64'd0);
      check("async_rst_valid", 64'(valid_o), 64'd0);
      check("async_rst_dac", 64'(dac_o), 64'd0);
      @(posedge clk); #2;
      @(posedge clk); #2;
      rst = 1'b0;
      for (int i = 0; i < 8; i++) step(1, 1, 1, 1, 0, pk(i < 4 ? 30 : 34, 8, 63));
      check("black_after_rst", 64'(blacklevel_o), 64'(pk(32, 8, 63)));
      step(1, 0, 1, 1, 0, pk(0, 0, 0));
      step(0, 0, 1, 1, 0, pk(0, 0, 0));
      check("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, errors %0d", errors);
      $fatal(1);
   end

endmodule
